// File: rtl/puzzle_pkg.sv
// Shared types for the button command decoder:
// move direction encoding, FSM states and count decode helpers.
package puzzle_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    HOLD    = 2'b10
  } state_t;

  localparam logic [2:0] CNT_MAX = 3'd7;

  function automatic dir_t cnt2dir(input logic [2:0] c);
    dir_t d;
    d = UP;
    unique case (c)
      3'd2:    d = DOWN;
      3'd3:    d = LEFT;
      3'd4:    d = RIGHT;
      default: d = UP;
    endcase
    return d;
  endfunction

  // Only bursts of 1..4 presses name a legal move.
  function automatic logic cnt_err(input logic [2:0] c);
    return (c == 3'd0) || (c > 3'd4);
  endfunction

endpackage

// File: rtl/btn_cmd_decoder_if.sv
// Decoded move command channel, valid/ready handshake.
// Master drives the command, slave (puzzle core) drives ready.
interface btn_cmd_decoder_if;
  import puzzle_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  dir_t       cmd_dir;
  logic [2:0] cmd_count;
  logic       cmd_err;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_count,
    output cmd_err,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_count,
    input  cmd_err,
    output cmd_ready
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a level debouncer:
// btn_level follows only after DEBOUNCE_CYCLES disagreeing cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        btn_level <= s2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_cmd_decoder.sv
// Counts debounced presses in a burst and, after a released gap,
// offers the burst as a move command on a valid/ready channel.
module btn_cmd_decoder
  import puzzle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn,
  btn_cmd_decoder_if.master        cmd,
  output logic                     btn_level,
  output logic                     busy,
  output logic                     cmd_drop
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t        state;
  state_t        state_n;
  logic [2:0]    cnt;
  logic [2:0]    cnt_n;
  logic [GW-1:0] gap;
  logic [GW-1:0] gap_n;
  logic          level_q;
  logic          press;
  logic          hold;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .btn_level (btn_level)
  );

  assign press = btn_level & ~level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gap     <= '0;
      level_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gap     <= gap_n;
      level_q <= btn_level;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gap_n    = gap;
    cmd_drop = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        if (press) begin
          state_n = COLLECT;
          cnt_n   = 3'd1;
          gap_n   = '0;
        end
      end
      state == COLLECT: begin
        if (press) begin
          cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 3'd1;
          gap_n = '0;
        end else if (btn_level) begin
          gap_n = '0;
        end else if (gap == GW'(GAP_CYCLES - 1)) begin
          state_n = HOLD;
          gap_n   = '0;
        end else begin
          gap_n = gap + 1'b1;
        end
      end
      state == HOLD: begin
        // Presses here can't join the offered burst; flag and discard.
        cmd_drop = press;
        if (cmd.cmd_ready) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        gap_n   = '0;
      end
    endcase
  end

  assign hold          = (state == HOLD);
  assign busy          = (state != IDLE);
  assign cmd.cmd_valid = hold;
  assign cmd.cmd_count = hold ? cnt : 3'd0;
  assign cmd.cmd_dir   = hold ? cnt2dir(cnt) : UP;
  assign cmd.cmd_err   = hold & cnt_err(cnt);

endmodule

// File: doc/btn_cmd_decoder.md
BTN_CMD_DECODER -- requirements
Module: btn_cmd_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized cycles required to accept a btn level change.
REQ-002 SHALL have parameter GAP_CYCLES, default 32, meaning the released-idle cycles that close a press burst.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port btn, input, 1 bit: raw asynchronous push-button level, high = pressed.
REQ-006 SHALL have port cmd_valid, output, 1 bit: decoded move command available.
REQ-007 SHALL have port cmd_ready, input, 1 bit: consumer (puzzle core) accepts the command.
REQ-008 SHALL have port cmd_dir, output, 2 bits: 00 up, 01 down, 10 left, 11 right.
REQ-009 SHALL have port cmd_count, output, 3 bits: presses in the burst, saturating at 7.
REQ-010 SHALL have port cmd_err, output, 1 bit: burst count outside 1..4.
REQ-011 SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-012 SHALL have port busy, output, 1 bit: FSM not in IDLE.
REQ-013 SHALL have port cmd_drop, output, 1 bit: one-cycle pulse when a press is discarded.

Function
REQ-014 SHALL pass btn through a 2-flop synchronizer before any other use.
REQ-015 SHALL update btn_level only when the synchronized value has differed from btn_level for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-016 SHALL treat a 0->1 transition of btn_level as one press; releases are not events.
REQ-017 SHALL implement FSM states IDLE, COLLECT and HOLD.
REQ-018 IDLE: a press -> COLLECT with count=1 and gap counter=0.
REQ-019 COLLECT: a press -> count+1 (saturating at 7) and gap=0; gap held at 0 while btn_level=1; gap increments while btn_level=0.
REQ-020 COLLECT: gap reaching GAP_CYCLES-1 -> HOLD, with cmd_valid=1 from the next cycle.
REQ-021 SHALL decode counts 1/2/3/4 to cmd_dir 00/01/10/11 with cmd_err=0; counts 5..7 give cmd_dir=00 and cmd_err=1.
REQ-022 HOLD: cmd_dir, cmd_count and cmd_err SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-023 HOLD: a cycle with cmd_valid&cmd_ready SHALL complete the transfer; cmd_valid=0 and state=IDLE on the next cycle.
REQ-024 A press in HOLD SHALL be discarded with cmd_drop=1 for exactly that cycle; a press coinciding with the handshake cycle is also discarded.
REQ-025 cmd_ready asserted outside HOLD SHALL have no effect.
REQ-026 Latency: raw btn rise -> btn_level rise SHALL be 2+DEBOUNCE_CYCLES cycles, +/-1 for asynchronous sampling.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, all counters and synchronizer flops to 0, btn_level=0, cmd_valid=0, cmd_dir=00, cmd_count=0, cmd_err=0, busy=0, cmd_drop=0.
REQ-028 Reset asserted mid-COLLECT or mid-HOLD SHALL abandon the burst with no command emitted afterwards.

Structure
REQ-029 A shared package puzzle_pkg SHALL hold the dir_t encoding (UP/DOWN/LEFT/RIGHT) and the FSM state typedef.
REQ-030 The synchronizer and debouncer SHALL form one sub-module, btn_debounce (ports clk, rst, btn, btn_level), instantiated once.

Verification (clk period 100 ps)
REQ-031 Reset: assert rst for 150 ps -> every output equals its REQ-027 value.
REQ-032 One press, btn high 10 cycles -> cmd_valid rises about GAP_CYCLES+1 cycles after btn_level falls, with cmd_dir=00, cmd_count=1, cmd_err=0.
REQ-033 Four presses, 10 cycles high and 10 cycles low each -> one command: cmd_dir=11, cmd_count=4, cmd_err=0.
REQ-034 Six presses, 10 cycles high and 10 cycles low each -> cmd_count=6, cmd_err=1, cmd_dir=00.
REQ-035 Glitch: btn high for 2 cycles -> btn_level stays 0, busy stays 0, no command.
REQ-036 Hold cmd_ready=0 for 40 cycles in HOLD and press once -> outputs stable and cmd_drop pulses once; then cmd_ready=1 -> IDLE on the next cycle. Separately, rst mid-COLLECT -> IDLE with no command.
